// File: rtl/id_ex_core_if.sv
// Decode/execute bus between the pipeline and id_ex_core.
// Carries decoder, register-file and ALU signals.
interface id_ex_core_if;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [31:0] out_rs;
   logic [31:0] out_rt;
   logic        sinal_escrita;
   logic [4:0]  reg_escrita;
   logic [31:0] dado_escrita;
   logic [1:0]  c_ALUOp;
   logic [1:0]  c_memoria;
   logic [2:0]  c_desvio;
   logic        c_fonte_ula;
   logic        c_memtoreg;
   logic        c_escrever_reg;
   logic        c_reg_destino;
   logic [2:0]  sinal_operacao;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] resultado;
   logic        zero;
   logic        overflow;

   modport master (
      output opcode, rs, rt, sinal_escrita, reg_escrita, dado_escrita,
      output sinal_operacao, alu_a, alu_b,
      input  out_rs, out_rt, c_ALUOp, c_memoria, c_desvio, c_fonte_ula,
      input  c_memtoreg, c_escrever_reg, c_reg_destino,
      input  resultado, zero, overflow
   );

   modport slave (
      input  opcode, rs, rt, sinal_escrita, reg_escrita, dado_escrita,
      input  sinal_operacao, alu_a, alu_b,
      output out_rs, out_rt, c_ALUOp, c_memoria, c_desvio, c_fonte_ula,
      output c_memtoreg, c_escrever_reg, c_reg_destino,
      output resultado, zero, overflow
   );
endinterface

// File: rtl/id_ex_core.sv
// MIPS32 decode/execute core: control decoder,
// 32x32 register file with write bypass, and ALU.
module id_ex_core (
   input logic    clock,
   input logic    reset,
   id_ex_core_if.slave bus
);

   logic [31:0] regs [32];
   logic        wr_ok;
   logic        byp_ok;
   logic [31:0] sum;
   logic [31:0] diff;

   assign wr_ok  = bus.sinal_escrita && (bus.reg_escrita != 5'd0);
   assign byp_ok = wr_ok && !reset;

   // Register file update; reset wins over a same-edge write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[bus.reg_escrita] <= bus.dado_escrita;
      end
   end

   // Read ports: r0 is hardwired zero, pending write is bypassed.
   always_comb begin
      bus.out_rs = regs[bus.rs];
      bus.out_rt = regs[bus.rt];
      if (byp_ok && bus.reg_escrita == bus.rs)
         bus.out_rs = bus.dado_escrita;
      if (byp_ok && bus.reg_escrita == bus.rt)
         bus.out_rt = bus.dado_escrita;
      if (bus.rs == 5'd0)
         bus.out_rs = '0;
      if (bus.rt == 5'd0)
         bus.out_rt = '0;
   end

   // Main control decoder; unknown opcodes decode as a NOP.
   always_comb begin
      bus.c_ALUOp        = 2'b00;
      bus.c_memoria      = 2'b00;
      bus.c_desvio       = 3'b000;
      bus.c_fonte_ula    = 1'b0;
      bus.c_memtoreg     = 1'b0;
      bus.c_escrever_reg = 1'b0;
      bus.c_reg_destino  = 1'b0;
      case (bus.opcode)
         6'b000000: begin
            bus.c_ALUOp        = 2'b10;
            bus.c_escrever_reg = 1'b1;
            bus.c_reg_destino  = 1'b1;
         end
         6'b100011: begin
            bus.c_memoria      = 2'b01;
            bus.c_fonte_ula    = 1'b1;
            bus.c_memtoreg     = 1'b1;
            bus.c_escrever_reg = 1'b1;
         end
         6'b101011: begin
            bus.c_memoria   = 2'b10;
            bus.c_fonte_ula = 1'b1;
         end
         6'b000100: begin
            bus.c_ALUOp  = 2'b01;
            bus.c_desvio = 3'b001;
         end
         6'b000101: begin
            bus.c_ALUOp  = 2'b01;
            bus.c_desvio = 3'b010;
         end
         6'b000010: bus.c_desvio = 3'b011;
         6'b000011: bus.c_desvio = 3'b100;
         6'b001000: begin
            bus.c_fonte_ula    = 1'b1;
            bus.c_escrever_reg = 1'b1;
         end
         default: ;
      endcase
   end

   assign sum  = bus.alu_a + bus.alu_b;
   assign diff = bus.alu_a - bus.alu_b;

   // ALU result and signed-overflow flag for ADD/SUB only.
   always_comb begin
      bus.resultado = '0;
      bus.overflow  = 1'b0;
      case (bus.sinal_operacao)
         3'b000: bus.resultado = bus.alu_a & bus.alu_b;
         3'b001: bus.resultado = bus.alu_a | bus.alu_b;
         3'b011: bus.resultado = ~(bus.alu_a | bus.alu_b);
         3'b010: begin
            bus.resultado = sum;
            bus.overflow  = (bus.alu_a[31] == bus.alu_b[31]) &&
                            (sum[31] != bus.alu_a[31]);
         end
         3'b110: begin
            bus.resultado = diff;
            bus.overflow  = (bus.alu_a[31] != bus.alu_b[31]) &&
                            (diff[31] != bus.alu_a[31]);
         end
         3'b111:
            bus.resultado = {31'd0,
                             $signed(bus.alu_a) < $signed(bus.alu_b)};
         default: ;
      endcase
   end

   assign bus.zero = (bus.resultado == 32'd0);

endmodule

// File: tb/tb_id_ex_core.sv
// Directed self-checking bench for id_ex_core.
// Covers register file, bypass, reset, decoder and ALU.
module tb_id_ex_core;

   logic clock;
   logic reset;
   int   n_total;
   int   n_pass;

   id_ex_core_if bus ();

   id_ex_core dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic alu(input string tag, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic z,
                      input logic o);
      bus.sinal_operacao = op;
      bus.alu_a = a;
      bus.alu_b = b;
      #1;
      chk({tag, "_res"}, {32'd0, bus.resultado}, {32'd0, r});
      chk({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, z});
      chk({tag, "_ovf"}, {63'd0, bus.overflow}, {63'd0, o});
   endtask

   task automatic dec(input string tag, input logic [5:0] op,
                      input logic [10:0] exp);
      bus.opcode = op;
      #1;
      chk(tag, {53'd0, bus.c_ALUOp, bus.c_memoria, bus.c_desvio,
                bus.c_fonte_ula, bus.c_memtoreg,
                bus.c_escrever_reg, bus.c_reg_destino},
          {53'd0, exp});
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset = 1'b0;
      bus.opcode = '0;
      bus.rs = '0;
      bus.rt = '0;
      bus.sinal_escrita = 1'b0;
      bus.reg_escrita = '0;
      bus.dado_escrita = '0;
      bus.sinal_operacao = '0;
      bus.alu_a = '0;
      bus.alu_b = '0;

      // reset, then read r5/r31
      #2;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bus.rs = 5'd5;
      bus.rt = 5'd31;
      #1;
      chk("rst_r5", {32'd0, bus.out_rs}, 64'd0);
      chk("rst_r31", {32'd0, bus.out_rt}, 64'd0);

      // write to r0 is ignored, no bypass either
      bus.sinal_escrita = 1'b1;
      bus.reg_escrita = 5'd0;
      bus.dado_escrita = 32'hDEADBEEF;
      bus.rs = 5'd0;
      #1;
      chk("r0_byp", {32'd0, bus.out_rs}, 64'd0);
      tick();
      bus.sinal_escrita = 1'b0;
      #1;
      chk("r0_store", {32'd0, bus.out_rs}, 64'd0);

      // r7 write with same-cycle read
      bus.sinal_escrita = 1'b1;
      bus.reg_escrita = 5'd7;
      bus.dado_escrita = 32'h12345678;
      bus.rs = 5'd7;
      #1;
      chk("r7_byp", {32'd0, bus.out_rs}, 64'h12345678);
      tick();
      bus.sinal_escrita = 1'b0;
      #1;
      chk("r7_store", {32'd0, bus.out_rs}, 64'h12345678);

      // write r8 under reset: no bypass, reset wins
      reset = 1'b1;
      bus.sinal_escrita = 1'b1;
      bus.reg_escrita = 5'd8;
      bus.dado_escrita = 32'hAAAA5555;
      bus.rs = 5'd8;
      bus.rt = 5'd7;
      #1;
      chk("r8_nobyp", {32'd0, bus.out_rs}, 64'd0);
      tick();
      reset = 1'b0;
      bus.sinal_escrita = 1'b0;
      #1;
      chk("r8_rst", {32'd0, bus.out_rs}, 64'd0);
      chk("r7_rst", {32'd0, bus.out_rt}, 64'd0);

      // decoder sweep
      dec("dec_r",    6'b000000, 11'b10_00_000_0_0_1_1);
      dec("dec_lw",   6'b100011, 11'b00_01_000_1_1_1_0);
      dec("dec_sw",   6'b101011, 11'b00_10_000_1_0_0_0);
      dec("dec_beq",  6'b000100, 11'b01_00_001_0_0_0_0);
      dec("dec_bne",  6'b000101, 11'b01_00_010_0_0_0_0);
      dec("dec_j",    6'b000010, 11'b00_00_011_0_0_0_0);
      dec("dec_jal",  6'b000011, 11'b00_00_100_0_0_0_0);
      dec("dec_addi", 6'b001000, 11'b00_00_000_1_0_1_0);
      dec("dec_nop",  6'b111111, 11'b00_00_000_0_0_0_0);

      // ALU
      alu("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h1,
          32'h80000000, 1'b0, 1'b1);
      alu("add", 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
      alu("sub_zero", 3'b110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
      alu("sub_ovf", 3'b110, 32'h80000000, 32'h1,
          32'h7FFFFFFF, 1'b0, 1'b1);
      alu("sub_ovf2", 3'b110, 32'h0, 32'h80000000,
          32'h80000000, 1'b0, 1'b1);
      alu("and", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00,
          32'hF000F000, 1'b0, 1'b0);
      alu("or", 3'b001, 32'hF0F0F0F0, 32'hFF00FF00,
          32'hFFF0FFF0, 1'b0, 1'b0);
      alu("nor", 3'b011, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
      alu("slt_t", 3'b111, 32'hFFFFFFFF, 32'h1, 32'd1, 1'b0, 1'b0);
      alu("slt_f", 3'b111, 32'h1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
      alu("slt_big", 3'b111, 32'h80000000, 32'h7FFFFFFF,
          32'd1, 1'b0, 1'b0);
      alu("op100", 3'b100, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0);

      // back-to-back writes r1..r31 = i*3
      bus.rs = 5'd0;
      for (int i = 1; i < 32; i++) begin
         bus.sinal_escrita = 1'b1;
         bus.reg_escrita = 5'(i);
         bus.dado_escrita = 32'(i * 3);
         bus.rt = 5'(i);
         #1;
         chk("b2b_byp", {32'd0, bus.out_rt}, 64'(i * 3));
         chk("b2b_r0", {32'd0, bus.out_rs}, 64'd0);
         tick();
      end
      bus.sinal_escrita = 1'b0;
      for (int i = 0; i < 32; i++) begin
         bus.rs = 5'(i);
         bus.rt = 5'(31 - i);
         #1;
         chk("rd_a", {32'd0, bus.out_rs}, 64'(i * 3));
         chk("rd_b", {32'd0, bus.out_rt}, 64'((31 - i) * 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/id_ex_core.md
Name: id_ex_core

Overview:
- Combined decode/execute core for the 5-stage MIPS32 pipeline, holding three sub-functions:
  - main control decoder (opcode to pipeline micro-signals);
  - 32x32 register file with two read ports, one write port and write-to-read bypass;
  - 32-bit ALU with zero and overflow flags.
- Sits between IF/ID and ID/EX pipeline registers; the ALU section is driven by the EX stage with forwarded operands.

Parameters:
- None. Data width is fixed at 32; register count is fixed at 32.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears the register file
- opcode  in  6  instruction[31:26]
- rs  in  5  read address A
- rt  in  5  read address B
- out_rs  out  32  read data A (combinational)
- out_rt  out  32  read data B (combinational)
- sinal_escrita  in  1  register write enable (WB stage)
- reg_escrita  in  5  write address
- dado_escrita  in  32  write data
- c_ALUOp  out  2  ALU class: 00 add, 01 sub/compare, 10 R-type funct
- c_memoria  out  2  bit0 memory read, bit1 memory write
- c_desvio  out  3  000 none, 001 beq, 010 bne, 011 j, 100 jal, 101 jr
- c_fonte_ula  out  1  1 = ALU B operand is the immediate
- c_memtoreg  out  1  1 = writeback from memory
- c_escrever_reg  out  1  register write
- c_reg_destino  out  1  1 = destination rd, 0 = rt
- sinal_operacao  in  3  ALU operation select
- alu_a  in  32  ALU operand A
- alu_b  in  32  ALU operand B
- resultado  out  32  ALU result
- zero  out  1  resultado == 0
- overflow  out  1  signed overflow

Behaviour:

Control decoder (purely combinational). Bits are listed in port order c_ALUOp / c_memoria / c_desvio / c_fonte_ula / c_memtoreg / c_escrever_reg / c_reg_destino:
- 000000 R-type: 10/00/000/0/0/1/1
- 100011 lw: 00/01/000/1/1/1/0
- 101011 sw: 00/10/000/1/0/0/0
- 000100 beq: 01/00/001/0/0/0/0
- 000101 bne: 01/00/010/0/0/0/0
- 000010 j: 00/00/011/0/0/0/0
- 000011 jal: 00/00/100/0/0/0/0 (link write is not done here)
- 001000 addi: 00/00/000/1/0/1/0
- Any other opcode: all outputs 0, which makes it a NOP.
- c_desvio 101 (jr) is reserved; this decoder never produces it.

Register file:
- 32 registers of 32 bits.
- Write: on rising clock edge when sinal_escrita=1 and reg_escrita != 0.
- Register 0 always reads 0; writes to it are ignored.
- Reads are combinational.
- Bypass: if sinal_escrita=1, reg_escrita != 0, reset=0, and the write address equals a read address, that read port returns dado_escrita in the same cycle. This gives write-before-read in one cycle.
- Reset: on a rising edge with reset=1, all registers become 0.
  - Reset overrides a simultaneous write.
  - Bypass is suppressed while reset=1.
- Initial contents before the first reset are undefined.
- Reset does not affect the decoder or the ALU.

ALU (purely combinational, zero latency):
- 000 AND
- 001 OR
- 010 ADD (modulo 2^32)
- 110 SUB, computed as alu_a - alu_b
- 111 SLT: signed compare, result 1 if alu_a < alu_b else 0
- 011 NOR
- Any other code: result 0.
- overflow is asserted only for ADD/SUB with two's-complement signed overflow:
  - ADD: operands have the same sign and the result sign differs.
  - SUB: operands have different signs and the result sign differs from alu_a.
  - SLT uses the true signed comparison, independent of overflow.
  - overflow = 0 for all other operations.
- zero reflects the final result for every operation.

Test Plan:
- Reset and read: assert reset one cycle, then read rs=5, rt=31 -> out_rs=0, out_rt=0. Write 0xDEADBEEF to r0 -> r0 still reads 0.
- Write, bypass and reset priority:
  - Write r7=0x12345678 with rs=7 in the same cycle -> out_rs=0x12345678 before the edge (bypass) and after it (stored).
  - Write r8 with reset=1 -> r8 reads 0.
- Decoder sweep: apply all 8 defined opcodes plus 111111 -> outputs match the table exactly; 111111 gives all zeros.
- ALU arithmetic:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1.
  - SUB 5-5 -> 0, zero=1, overflow=0.
  - SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
- ALU logic and compare:
  - AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000.
  - OR the same operands -> 0xFFF0FFF0.
  - NOR 0,0 -> 0xFFFFFFFF.
  - SLT 0xFFFFFFFF(-1),1 -> 1.
  - SLT 1,-1 -> 0, zero=1.
  - Op 100 -> 0.
- Back-to-back writes: write r1..r31 with value = index×3 on consecutive cycles, then read pairs -> each returns index×3; r0 reads 0 throughout.
